// File: rtl/rf_alu_sequencer.sv
// Sequences one load or R-format instruction at a time through the RF_ALU block (read, execute, write back).
// Latency: instr ALU_LAT+2, load 2, illegal 1 cycles to done; sources hold their request until ready.
module rf_alu_sequencer #(
  parameter int ALU_LAT = 1,
  parameter int XLEN    = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_reg,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic [4:0]      Read1,
  output logic [4:0]      Read2,
  output logic [4:0]      WriteReg,
  output logic [XLEN-1:0] WriteData,
  output logic            RegWrite,
  output logic [1:0]      ALUOp,
  output logic [10:0]     OpcodeField,
  input  logic [XLEN-1:0] ALU_Result,
  input  logic            zero,
  output logic [XLEN-1:0] result,
  output logic            result_zero,
  output logic            done,
  output logic            illegal
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [3:0]  LAST_CNT = 4'(ALU_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [4:0]        r_read1;
  logic [4:0]        r_read2;
  logic [4:0]        r_wreg;
  logic [XLEN-1:0]   r_wdata;
  logic [1:0]        r_aluop;
  logic [10:0]       r_opcode;
  logic [XLEN-1:0]   r_result;
  logic              r_zero;
  logic              r_illegal;

  logic              w_ld_acc;
  logic              w_in_acc;
  logic              w_supported;
  logic              w_exec_last;
  logic              w_unused_shamt;

  assign w_unused_shamt = ^instr[15:10];

  assign ld_ready    = (r_state == S_IDLE);
  assign instr_ready = (r_state == S_IDLE) && !ld_valid;
  assign w_ld_acc    = ld_ready && ld_valid;
  assign w_in_acc    = instr_ready && instr_valid;
  assign w_supported = (instr[31:21] == OP_AND) || (instr[31:21] == OP_ORR) ||
                       (instr[31:21] == OP_ADD) || (instr[31:21] == OP_SUB);
  assign w_exec_last = (r_state == S_EXEC) && (r_cnt == LAST_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ld_acc)      w_next = S_WRITE;
        else if (w_in_acc) w_next = w_supported ? S_EXEC : S_DONE;
      end
      S_EXEC:  if (w_exec_last) w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_read1   <= '0;
      r_read2   <= '0;
      r_wreg    <= '0;
      r_wdata   <= '0;
      r_aluop   <= '0;
      r_opcode  <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_ld_acc) begin
        r_wreg    <= ld_reg;
        r_wdata   <= ld_data;
        r_illegal <= 1'b0;
      end else if (w_in_acc) begin
        r_read1   <= instr[9:5];
        r_read2   <= instr[20:16];
        r_wreg    <= instr[4:0];
        r_opcode  <= instr[31:21];
        r_aluop   <= w_supported ? 2'b10 : 2'b00;
        r_illegal <= !w_supported;
        r_cnt     <= '0;
      end
      if (r_state == S_EXEC) begin
        if (w_exec_last) begin
          r_result <= ALU_Result;
          r_zero   <= zero;
          r_wdata  <= ALU_Result;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
      // ALUOp is back to 00 by the time done is visible
      if (r_state == S_WRITE) r_aluop <= 2'b00;
    end
  end

  assign Read1       = r_read1;
  assign Read2       = r_read2;
  assign WriteReg    = r_wreg;
  assign WriteData   = r_wdata;
  assign RegWrite    = (r_state == S_WRITE) && (r_wreg != 5'd31);
  assign ALUOp       = r_aluop;
  assign OpcodeField = r_opcode;
  assign result      = r_result;
  assign result_zero = r_zero;
  assign done        = (r_state == S_DONE);
  assign illegal     = (r_state == S_DONE) && r_illegal;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Directed bench for rf_alu_sequencer with a behavioural register file and ALU as its environment.
module tb_rf_alu_sequencer;

  localparam logic [63:0] ALL5 = 64'h5555555555555555;
  localparam logic [63:0] ALLA = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        ld_valid;
  logic [4:0]  ld_reg;
  logic [63:0] ld_data;
  logic        ld_ready;
  logic [4:0]  Read1;
  logic [4:0]  Read2;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
  logic        RegWrite;
  logic [1:0]  ALUOp;
  logic [10:0] OpcodeField;
  logic [63:0] ALU_Result;
  logic        zero;
  logic [63:0] result;
  logic        result_zero;
  logic        done;
  logic        illegal;

  int tests_run = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int wr_cnt    = 0;
  int aluop_cnt = 0;
  logic [4:0]  last_wreg;
  logic [63:0] last_wdat;
  logic [63:0] rf [32];

  rf_alu_sequencer #(.ALU_LAT(1), .XLEN(64)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
    .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg), .WriteData(WriteData),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .OpcodeField(OpcodeField),
    .ALU_Result(ALU_Result), .zero(zero),
    .result(result), .result_zero(result_zero), .done(done), .illegal(illegal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Register file and write-strobe observer
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (RegWrite) begin
      wr_cnt    <= wr_cnt + 1;
      last_wreg <= WriteReg;
      last_wdat <= WriteData;
      if (WriteReg != 5'd31) rf[WriteReg] <= WriteData;
    end
    if (ALUOp != 2'b00) aluop_cnt <= aluop_cnt + 1;
  end

  always_comb begin
    ALU_Result = '0;
    case (OpcodeField)
      11'b10001010000: ALU_Result = rf[Read1] & rf[Read2];
      11'b10101010000: ALU_Result = rf[Read1] | rf[Read2];
      11'b10001011000: ALU_Result = rf[Read1] + rf[Read2];
      11'b11001011000: ALU_Result = rf[Read1] - rf[Read2];
      default:         ALU_Result = '0;
    endcase
    zero = (ALU_Result == 64'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_load(input logic [4:0] r, input logic [63:0] d);
    int k;
    k = 0;
    ld_reg = r; ld_data = d; ld_valid = 1'b1;
    #1;
    while (!ld_ready && k < 20) begin @(posedge clock); #1; k++; end
    @(posedge clock); #1;
    ld_valid = 1'b0;
  endtask

  task automatic issue_instr(input logic [31:0] ins, output int acc_cyc);
    int k;
    k = 0;
    instr = ins; instr_valid = 1'b1;
    #1;
    while (!instr_ready && k < 20) begin @(posedge clock); #1; k++; end
    acc_cyc = cyc;
    @(posedge clock); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic ill, output int dcyc);
    int n;
    n = 0;
    while (!done && n < 20) begin @(posedge clock); #1; n++; end
    lat  = n + 1;
    ill  = illegal;
    dcyc = cyc;
  endtask

  initial begin
    int   lat, acc, dcyc, w0, a0, k;
    logic ill;
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    ld_valid = 1'b0; ld_reg = '0; ld_data = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 64'({instr_ready, ld_ready}), 64'd3);
    chk("rst_flags", 64'({RegWrite, done, illegal, ALUOp, result_zero}), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_wdata", WriteData, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Direct loads
    w0 = wr_cnt;
    issue_load(5'd5, ALL5);
    chk("ld5_regwrite", 64'(RegWrite), 64'd1);
    chk("ld5_wreg", 64'(WriteReg), 64'd5);
    chk("ld5_wdata", WriteData, ALL5);
    wait_done(lat, ill, dcyc);
    chk("ld5_lat", 64'(lat), 64'd2);
    chk("ld5_writes", 64'(wr_cnt - w0), 64'd1);
    chk("ld5_regwrite_at_done", 64'(RegWrite), 64'd0);

    w0 = wr_cnt;
    issue_load(5'd10, ALLA);
    chk("ld10_wreg", 64'(WriteReg), 64'd10);
    chk("ld10_wdata", WriteData, ALLA);
    wait_done(lat, ill, dcyc);
    chk("ld10_lat", 64'(lat), 64'd2);
    chk("ld10_writes", 64'(wr_cnt - w0), 64'd1);

    // ADD X1, X5, X10
    w0 = wr_cnt;
    issue_instr(32'h8B0A00A1, acc);
    chk("add_read1", 64'(Read1), 64'd5);
    chk("add_read2", 64'(Read2), 64'd10);
    chk("add_aluop", 64'(ALUOp), 64'd2);
    chk("add_opcode", 64'(OpcodeField), 64'(11'b10001011000));
    wait_done(lat, ill, dcyc);
    chk("add_lat", 64'(lat), 64'd3);
    chk("add_illegal", 64'(ill), 64'd0);
    chk("add_writes", 64'(wr_cnt - w0), 64'd1);
    chk("add_wreg", 64'(last_wreg), 64'd1);
    chk("add_wdata", last_wdat, ONES);
    chk("add_result", result, ONES);
    chk("add_zero", 64'(result_zero), 64'd0);
    @(posedge clock); #1;
    chk("add_done_pulse", 64'(done), 64'd0);
    chk("add_read1_hold", 64'(Read1), 64'd5);

    // SUB X2, X5, X5 then AND X3, X5, X10 back to back
    issue_instr(32'hCB0500A2, acc);
    wait_done(lat, ill, dcyc);
    chk("sub_lat", 64'(lat), 64'd3);
    chk("sub_wreg", 64'(last_wreg), 64'd2);
    chk("sub_wdata", last_wdat, 64'd0);
    chk("sub_zero", 64'(result_zero), 64'd1);
    issue_instr(32'h8A0A00A3, acc);
    chk("b2b_gap", 64'(acc - dcyc), 64'd1);
    wait_done(lat, ill, dcyc);
    chk("and_lat", 64'(lat), 64'd3);
    chk("and_wreg", 64'(last_wreg), 64'd3);
    chk("and_wdata", last_wdat, 64'd0);
    chk("and_zero", 64'(result_zero), 64'd1);

    // ORR XZR, X5, X10
    w0 = wr_cnt;
    issue_instr(32'hAA0A00BF, acc);
    wait_done(lat, ill, dcyc);
    chk("orr_lat", 64'(lat), 64'd3);
    chk("orr_result", result, ONES);
    chk("orr_zero", 64'(result_zero), 64'd0);
    chk("orr_xzr_nowrite", 64'(wr_cnt - w0), 64'd0);

    // Unsupported opcode
    w0 = wr_cnt; a0 = aluop_cnt;
    issue_instr(32'hFFE000A1, acc);
    wait_done(lat, ill, dcyc);
    chk("ill_lat", 64'(lat), 64'd1);
    chk("ill_flag", 64'(ill), 64'd1);
    chk("ill_aluop", 64'(ALUOp), 64'd0);
    @(posedge clock); #1;
    chk("ill_pulse", 64'({done, illegal}), 64'd0);
    chk("ill_nowrite", 64'(wr_cnt - w0), 64'd0);
    chk("ill_aluop_quiet", 64'(aluop_cnt - a0), 64'd0);

    // Reset during EXEC of ADD X4, X5, X10
    w0 = wr_cnt;
    issue_instr(32'h8B0A00A4, acc);
    chk("rexec_aluop_pre", 64'(ALUOp), 64'd2);
    reset = 1'b1;
    #1;
    chk("rexec_ready", 64'({instr_ready, ld_ready}), 64'd3);
    chk("rexec_flags", 64'({RegWrite, done, ALUOp, result_zero}), 64'd0);
    chk("rexec_result", result, 64'd0);
    chk("rexec_read1", 64'(Read1), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rexec_nowrite", 64'(wr_cnt - w0), 64'd0);

    // Reset while RegWrite is high
    w0 = wr_cnt;
    issue_load(5'd8, 64'h77);
    chk("rwr_regwrite_pre", 64'(RegWrite), 64'd1);
    reset = 1'b1;
    #1;
    chk("rwr_regwrite_drop", 64'(RegWrite), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rwr_nowrite", 64'(wr_cnt - w0), 64'd0);

    // Both requests offered, reset, then load wins
    w0 = wr_cnt;
    ld_reg = 5'd6; ld_data = 64'h1234; ld_valid = 1'b1;
    instr = 32'h8B0A00A7; instr_valid = 1'b1;
    #1;
    chk("both_instr_ready", 64'(instr_ready), 64'd0);
    chk("both_ld_ready", 64'(ld_ready), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("both_rst_flags", 64'({RegWrite, done, ALUOp}), 64'd0);
    chk("both_rst_nowrite", 64'(wr_cnt - w0), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    ld_valid = 1'b0;
    chk("both_ld_first", 64'(RegWrite), 64'd1);
    chk("both_ld_wreg", 64'(WriteReg), 64'd6);
    chk("both_ld_wdata", WriteData, 64'h1234);
    wait_done(lat, ill, dcyc);
    chk("both_ld_lat", 64'(lat), 64'd2);
    k = 0;
    while (ALUOp != 2'b10 && k < 20) begin @(posedge clock); #1; k++; end
    instr_valid = 1'b0;
    chk("both_instr_accept", 64'(ALUOp), 64'd2);
    chk("both_instr_wreg", 64'(WriteReg), 64'd7);
    wait_done(lat, ill, dcyc);
    chk("both_instr_lat", 64'(lat), 64'd3);
    chk("both_instr_wdata", last_wdat, ONES);
    chk("both_total_writes", 64'(wr_cnt - w0), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule
